// File: rtl/grid_fire_ctrl.sv
// Target-grid game controller: one FSM owns the whole cell array, resolves
// aimed fire pulses to hit/miss/repeat and tracks shots, hits and game end.
module grid_fire_ctrl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int MAX_SHOTS = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_en,
    input  logic [ROWS*COLS-1:0]               ship_map,
    input  logic [ROWS-1:0]                    row_oh,
    input  logic [COLS-1:0]                    col_oh,
    input  logic                               fire,
    input  logic                               reveal,
    output logic [2*ROWS*COLS-1:0]             cell_state,
    output logic                               sel_error,
    output logic [$clog2(MAX_SHOTS+1)-1:0]     shots,
    output logic [$clog2(ROWS*COLS+1)-1:0]     hits,
    output logic                               result_valid,
    output logic [1:0]                         result,
    output logic                               game_over,
    output logic                               win
);

    localparam int NCELLS = ROWS * COLS;
    localparam int SHOT_W = $clog2(MAX_SHOTS + 1);
    localparam int HIT_W  = $clog2(NCELLS + 1);
    localparam int IDX_W  = $clog2(NCELLS);

    localparam logic [1:0] C_WATER = 2'b00;
    localparam logic [1:0] C_SHIP  = 2'b01;
    localparam logic [1:0] C_MISS  = 2'b10;
    localparam logic [1:0] C_HIT   = 2'b11;

    localparam logic [1:0] R_REPEAT = 2'b00;
    localparam logic [1:0] R_MISS   = 2'b01;
    localparam logic [1:0] R_HIT    = 2'b10;

    typedef enum logic [1:0] {IDLE, ARMED, RESOLVE, OVER} state_t;

    state_t              state_q, state_d;
    logic [1:0]          cells_q [NCELLS];
    logic [1:0]          cells_d [NCELLS];
    logic [HIT_W-1:0]    ship_total_q, ship_total_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [SHOT_W-1:0]   shots_q, shots_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                game_over_q, game_over_d;
    logic                win_q, win_d;
    logic                sel_error_q, sel_error_d;

    logic                sel_ok;
    logic [IDX_W-1:0]    sel_idx;
    logic [HIT_W-1:0]    map_pop;
    logic [HIT_W-1:0]    hits_upd;
    logic [SHOT_W-1:0]   shots_upd;
    int                  row_cnt, col_cnt, row_idx, col_idx;

    // Same-cycle decode of the one-hot aim; fire acts on this, not on sel_error.
    always_comb begin
        row_cnt = 0;
        col_cnt = 0;
        row_idx = 0;
        col_idx = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_oh[r]) begin
                row_cnt = row_cnt + 1;
                row_idx = r;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_oh[c]) begin
                col_cnt = col_cnt + 1;
                col_idx = c;
            end
        end
        sel_ok  = (row_cnt == 1) && (col_cnt == 1);
        sel_idx = IDX_W'(row_idx * COLS + col_idx);
    end

    always_comb begin
        map_pop = '0;
        for (int i = 0; i < NCELLS; i++) begin
            map_pop = map_pop + HIT_W'(ship_map[i]);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves a latch.
        state_d        = state_q;
        cells_d        = cells_q;
        ship_total_d   = ship_total_q;
        hits_d         = hits_q;
        shots_d        = shots_q;
        idx_d          = idx_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        game_over_d    = game_over_q;
        win_d          = win_q;
        sel_error_d    = !sel_ok;
        hits_upd       = hits_q;
        shots_upd      = shots_q;

        // A valid load wins over everything, including a shot pending in RESOLVE.
        if (load_en && (ship_map != '0)) begin
            for (int i = 0; i < NCELLS; i++) begin
                cells_d[i] = ship_map[i] ? C_SHIP : C_WATER;
            end
            ship_total_d = map_pop;
            hits_d       = '0;
            shots_d      = '0;
            result_d     = R_REPEAT;
            game_over_d  = 1'b0;
            win_d        = 1'b0;
            state_d      = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (fire && sel_ok) begin
                        idx_d   = sel_idx;
                        state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    result_valid_d = 1'b1;
                    case (cells_q[idx_q])
                        C_SHIP: begin
                            cells_d[idx_q] = C_HIT;
                            hits_upd       = hits_q + HIT_W'(1);
                            shots_upd      = shots_q + SHOT_W'(1);
                            result_d       = R_HIT;
                        end
                        C_WATER: begin
                            cells_d[idx_q] = C_MISS;
                            shots_upd      = shots_q + SHOT_W'(1);
                            result_d       = R_MISS;
                        end
                        default: result_d = R_REPEAT;
                    endcase
                    hits_d  = hits_upd;
                    shots_d = shots_upd;
                    // Win is tested first so a final-shot sink still counts as a win.
                    if (hits_upd == ship_total_q) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                        win_d       = 1'b1;
                    end else if (shots_upd == SHOT_W'(MAX_SHOTS)) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                        win_d       = 1'b0;
                    end else begin
                        state_d = ARMED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            // NOTE: the cell array is reset like any other state; it is small flop storage, not a RAM.
            for (int i = 0; i < NCELLS; i++) begin
                cells_q[i] <= C_WATER;
            end
            ship_total_q   <= '0;
            hits_q         <= '0;
            shots_q        <= '0;
            idx_q          <= '0;
            result_q       <= R_REPEAT;
            result_valid_q <= 1'b0;
            game_over_q    <= 1'b0;
            win_q          <= 1'b0;
            sel_error_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            cells_q        <= cells_d;
            ship_total_q   <= ship_total_d;
            hits_q         <= hits_d;
            shots_q        <= shots_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            game_over_q    <= game_over_d;
            win_q          <= win_d;
            sel_error_q    <= sel_error_d;
        end
    end

    // Unhit ships stay hidden unless reveal is asserted.
    always_comb begin
        cell_state = '0;
        for (int i = 0; i < NCELLS; i++) begin
            cell_state[2*i +: 2] = (cells_q[i] == C_SHIP && !reveal) ? C_WATER : cells_q[i];
        end
    end

    assign sel_error    = sel_error_q;
    assign shots        = shots_q;
    assign hits         = hits_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign game_over    = game_over_q;
    assign win          = win_q;

endmodule

// File: tb/tb_grid_fire_ctrl.sv
// Bench for grid_fire_ctrl: directed scenarios plus random games scored
// against a cell-set model of the game rules.
module tb_grid_fire_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [15:0] ship_map = '0;
    logic [3:0]  row_oh = 4'b0001;
    logic [3:0]  col_oh = 4'b0001;
    logic        fire = 1'b0;
    logic        reveal = 1'b0;

    logic [31:0] cs_a, cs_b;
    logic        se_a, se_b;
    logic [4:0]  shots_a;
    logic [1:0]  shots_b;
    logic [4:0]  hits_a, hits_b;
    logic        rv_a, rv_b;
    logic [1:0]  res_a, res_b;
    logic        go_a, go_b;
    logic        win_a, win_b;

    int n_checks = 0;
    int n_pass   = 0;

    grid_fire_ctrl #(.ROWS(4), .COLS(4), .MAX_SHOTS(16)) dut_a (
        .clk(clk), .reset(reset), .load_en(load_en), .ship_map(ship_map),
        .row_oh(row_oh), .col_oh(col_oh), .fire(fire), .reveal(reveal),
        .cell_state(cs_a), .sel_error(se_a), .shots(shots_a), .hits(hits_a),
        .result_valid(rv_a), .result(res_a), .game_over(go_a), .win(win_a)
    );

    grid_fire_ctrl #(.ROWS(4), .COLS(4), .MAX_SHOTS(2)) dut_b (
        .clk(clk), .reset(reset), .load_en(load_en), .ship_map(ship_map),
        .row_oh(row_oh), .col_oh(col_oh), .fire(fire), .reveal(reveal),
        .cell_state(cs_b), .sel_error(se_b), .shots(shots_b), .hits(hits_b),
        .result_valid(rv_b), .result(res_b), .game_over(go_b), .win(win_b)
    );

    always #5 clk = ~clk;

    // Game model: sets of ship cells and shot cells, plus plain counters.
    bit         m_ship [16];
    bit         m_shot [16];
    int         m_shots, m_hits, m_total, m_max, m_state; // state: 0 idle, 1 playing, 2 over
    bit         m_win;
    logic [1:0] m_result;

    task automatic m_reset(input int max_shots);
        for (int i = 0; i < 16; i++) begin
            m_ship[i] = 1'b0;
            m_shot[i] = 1'b0;
        end
        m_shots = 0; m_hits = 0; m_total = 0; m_state = 0;
        m_win = 1'b0; m_result = 2'b00; m_max = max_shots;
    endtask

    task automatic m_load(input logic [15:0] map);
        if (map != 16'h0) begin
            for (int i = 0; i < 16; i++) begin
                m_ship[i] = map[i];
                m_shot[i] = 1'b0;
            end
            m_total = $countones(map);
            m_shots = 0; m_hits = 0; m_win = 1'b0; m_result = 2'b00; m_state = 1;
        end
    endtask

    task automatic m_fire(input logic [3:0] r_oh, input logic [3:0] c_oh, output bit fired);
        int r, c, i;
        fired = 1'b0;
        if (m_state != 1 || $countones(r_oh) != 1 || $countones(c_oh) != 1) return;
        r = 0; c = 0;
        for (int k = 0; k < 4; k++) begin
            if (r_oh[k]) r = k;
            if (c_oh[k]) c = k;
        end
        i = r * 4 + c;
        fired = 1'b1;
        if (m_shot[i]) begin
            m_result = 2'b00;
        end else begin
            m_shot[i] = 1'b1;
            m_shots++;
            if (m_ship[i]) begin
                m_hits++;
                m_result = 2'b10;
            end else begin
                m_result = 2'b01;
            end
        end
        if (m_hits == m_total) begin
            m_state = 2; m_win = 1'b1;
        end else if (m_shots == m_max) begin
            m_state = 2; m_win = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_cells(input logic show);
        logic [31:0] v = '0;
        for (int i = 0; i < 16; i++) begin
            if (m_shot[i])      v[2*i +: 2] = m_ship[i] ? 2'b11 : 2'b10;
            else if (m_ship[i]) v[2*i +: 2] = show ? 2'b01 : 2'b00;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] map);
        ship_map = map;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic do_fire(input logic [3:0] r_oh, input logic [3:0] c_oh);
        row_oh = r_oh;
        col_oh = c_oh;
        fire   = 1'b1;
        tick();
        fire   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [47:0] got;
        tick(); tick();
        got = {cs_a, se_a, shots_a, hits_a, rv_a, res_a, go_a, win_a};
        n_checks++; if (got !== 48'h0) $display("FAIL reset_held: got %h expected %h", got, 48'h0); else n_pass++;
        reset = 1'b0;
        do_load(16'h8000);
        do_fire(4'b0001, 4'b0001);
        do_fire(4'b0001, 4'b0010);
        do_fire(4'b0001, 4'b0100);
        n_checks++; if (shots_a !== 5'd3) $display("FAIL pre_reset_shots: got %0d expected 3", shots_a); else n_pass++;
        #2 reset = 1'b1;
        #1;
        got = {cs_a, se_a, shots_a, hits_a, rv_a, res_a, go_a, win_a};
        n_checks++; if (got !== 48'h0) $display("FAIL async_reset: got %h expected %h", got, 48'h0); else n_pass++;
        tick();
        reset = 1'b0;
        do_fire(4'b0010, 4'b0010);
        got = {cs_a, se_a, shots_a, hits_a, rv_a, res_a, go_a, win_a};
        n_checks++; if (got !== 48'h0) $display("FAIL idle_fire_ignored: got %h expected %h", got, 48'h0); else n_pass++;
    endtask

    task automatic test_single_ship_win();
        reveal = 1'b0;
        do_load(16'h0001);
        do_fire(4'b0001, 4'b0001);
        n_checks++; if (cs_a[1:0] !== 2'b11) $display("FAIL win_cell: got %b expected 11", cs_a[1:0]); else n_pass++;
        n_checks++; if ({hits_a, shots_a} !== {5'd1, 5'd1}) $display("FAIL win_counts: got hits %0d shots %0d expected 1 1", hits_a, shots_a); else n_pass++;
        n_checks++; if ({rv_a, res_a} !== 3'b110) $display("FAIL win_result: got rv %b res %b expected 1 10", rv_a, res_a); else n_pass++;
        n_checks++; if ({go_a, win_a} !== 2'b11) $display("FAIL win_flags: got go %b win %b expected 1 1", go_a, win_a); else n_pass++;
        do_fire(4'b0001, 4'b0010);
        n_checks++; if ({rv_a, shots_a, go_a} !== {1'b0, 5'd1, 1'b1}) $display("FAIL over_fire_ignored: got rv %b shots %0d go %b", rv_a, shots_a, go_a); else n_pass++;
    endtask

    task automatic test_miss_repeat();
        do_load(16'h8000);
        do_fire(4'b0001, 4'b0010);
        n_checks++; if ({rv_a, res_a, cs_a[3:2], shots_a} !== {1'b1, 2'b01, 2'b10, 5'd1}) $display("FAIL miss: got rv %b res %b cell %b shots %0d expected 1 01 10 1", rv_a, res_a, cs_a[3:2], shots_a); else n_pass++;
        tick();
        n_checks++; if ({rv_a, res_a} !== 3'b001) $display("FAIL result_hold: got rv %b res %b expected 0 01", rv_a, res_a); else n_pass++;
        do_fire(4'b0001, 4'b0010);
        n_checks++; if ({rv_a, res_a, cs_a[3:2], shots_a} !== {1'b1, 2'b00, 2'b10, 5'd1}) $display("FAIL repeat: got rv %b res %b cell %b shots %0d expected 1 00 10 1", rv_a, res_a, cs_a[3:2], shots_a); else n_pass++;
    endtask

    task automatic test_sel_error();
        row_oh = 4'b0011;
        col_oh = 4'b0001;
        fire   = 1'b1;
        tick();
        fire   = 1'b0;
        n_checks++; if (se_a !== 1'b1) $display("FAIL sel_error_set: got %b expected 1", se_a); else n_pass++;
        tick();
        n_checks++; if ({rv_a, shots_a, cs_a[1:0]} !== {1'b0, 5'd1, 2'b00}) $display("FAIL bad_sel_dropped: got rv %b shots %0d cell0 %b", rv_a, shots_a, cs_a[1:0]); else n_pass++;
        row_oh = 4'b0001;
        tick();
        n_checks++; if (se_a !== 1'b0) $display("FAIL sel_error_clear: got %b expected 0", se_a); else n_pass++;
    endtask

    task automatic test_reveal_load_priority();
        reveal = 1'b1;
        do_load(16'h8000);
        n_checks++; if (cs_a !== 32'h4000_0000) $display("FAIL reveal: got %h expected %h", cs_a, 32'h4000_0000); else n_pass++;
        row_oh = 4'b0001;
        col_oh = 4'b0001;
        fire   = 1'b1;
        tick();
        load_en  = 1'b1;
        ship_map = 16'h0003;
        tick();
        load_en = 1'b0;
        fire    = 1'b0;
        n_checks++; if ({rv_a, shots_a, go_a, cs_a} !== {1'b0, 5'd0, 1'b0, 32'h0000_0005}) $display("FAIL load_over_resolve: got rv %b shots %0d go %b cells %h", rv_a, shots_a, go_a, cs_a); else n_pass++;
        tick();
        n_checks++; if (rv_a !== 1'b0) $display("FAIL no_late_result: got %b expected 0", rv_a); else n_pass++;
        reveal = 1'b0;
    endtask

    task automatic test_budget();
        do_load(16'h8000);
        do_fire(4'b0001, 4'b0001);
        do_fire(4'b0001, 4'b0010);
        n_checks++; if ({go_b, win_b, shots_b, rv_b, res_b} !== {1'b1, 1'b0, 2'd2, 1'b1, 2'b01}) $display("FAIL budget_loss: got go %b win %b shots %0d rv %b res %b", go_b, win_b, shots_b, rv_b, res_b); else n_pass++;
        do_fire(4'b0001, 4'b0100);
        n_checks++; if ({rv_b, shots_b, cs_b[5:4]} !== {1'b0, 2'd2, 2'b00}) $display("FAIL budget_over_fire: got rv %b shots %0d cell2 %b", rv_b, shots_b, cs_b[5:4]); else n_pass++;
        do_load(16'h8000);
        n_checks++; if ({go_b, shots_b, cs_b} !== {1'b0, 2'd0, 32'h0}) $display("FAIL budget_reload: got go %b shots %0d cells %h", go_b, shots_b, cs_b); else n_pass++;
        do_load(16'h0020);
        do_fire(4'b0001, 4'b0001);
        do_fire(4'b0010, 4'b0010);
        n_checks++; if ({go_b, win_b, shots_b, hits_b, res_b} !== {1'b1, 1'b1, 2'd2, 5'd1, 2'b10}) $display("FAIL win_priority: got go %b win %b shots %0d hits %0d res %b", go_b, win_b, shots_b, hits_b, res_b); else n_pass++;
    endtask

    task automatic test_random_games();
        logic [47:0] got, exp;
        logic [15:0] map;
        bit          fired;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset(16);
        for (int g = 0; g < 24; g++) begin
            case ($urandom_range(0, 3))
                0:       map = 16'h0;
                1:       map = 16'(($urandom % 16'hFFFF) + 1);
                default: map = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            do_load(map);
            m_load(map);
            for (int k = 0; k < 20; k++) begin
                logic [3:0] r_oh, c_oh;
                r_oh = 4'h1 << $urandom_range(0, 3);
                c_oh = 4'h1 << $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) r_oh = 4'($urandom);
                reveal = 1'($urandom);
                do_fire(r_oh, c_oh);
                m_fire(r_oh, c_oh, fired);
                exp = {m_cells(reveal),
                       !($countones(r_oh) == 1 && $countones(c_oh) == 1),
                       5'(m_shots), 5'(m_hits), fired, m_result, (m_state == 2), m_win};
                got = {cs_a, se_a, shots_a, hits_a, rv_a, res_a, go_a, win_a};
                n_checks++;
                if (got !== exp) $display("FAIL random g%0d s%0d: got %h expected %h", g, k, got, exp);
                else n_pass++;
            end
        end
        reveal = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_ship_win();
        test_miss_repeat();
        test_sel_error();
        test_reveal_load_priority();
        test_budget();
        test_random_games();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grid_fire_ctrl.md
Name: grid_fire_ctrl

Overview:
Parametrised ROWS x COLS target-grid controller that replaces per-cell instances with one array-owning FSM. It loads a hidden ship map and accepts debounced, one-cycle fire pulses aimed by one-hot row/column selects. It resolves each shot to hit, miss or repeat, and counts shots and hits. It ends the game on win (all ships hit) or loss (shot budget exhausted). Its flattened 2-bit-per-cell output feeds the color decoders and display unit.

Parameters:
ROWS, 4, number of grid rows (2..16)
COLS, 4, number of grid columns (2..16)
MAX_SHOTS, 16, shot budget per game (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_en  in  1  one-cycle pulse: start a new game from ship_map
ship_map  in  ROWS*COLS  ship present per cell; index r*COLS+c
row_oh  in  ROWS  one-hot row select
col_oh  in  COLS  one-hot column select
fire  in  1  one-cycle fire pulse, already debounced and edge-detected
reveal  in  1  1 = show unhit ships on cell_state
cell_state  out  2*ROWS*COLS  per-cell display code, bits [2i+1:2i]: 00 blank, 01 ship (only when reveal=1), 10 miss, 11 hit
sel_error  out  1  registered: selection not exactly one row bit and one column bit
shots  out  $clog2(MAX_SHOTS+1)  valid shots taken this game
hits  out  $clog2(ROWS*COLS+1)  ship cells hit this game
result_valid  out  1  one-cycle pulse per resolved fire
result  out  2  01 miss, 10 hit, 00 repeat; holds until next result_valid
game_over  out  1  high in OVER state
win  out  1  valid when game_over=1: 1 = all ships hit

Behaviour:
- Reset (asynchronous, any state): FSM -> IDLE. All internal cell codes 00 and ship_total 0. Every output 0.
- Internal cell code: 00 water, 01 ship, 10 miss, 11 hit. cell_state shows 01 as 00 unless reveal=1. The reveal mask is combinational.
- sel_error is registered each cycle: 1 unless popcount(row_oh)==1 and popcount(col_oh)==1.
- States: IDLE, ARMED, RESOLVE, OVER.
- IDLE: fire is ignored.
- load_en in IDLE, ARMED or OVER with ship_map != 0, on the next edge:
  - cells = ship_map mapped 1->01, 0->00
  - ship_total = popcount(ship_map)
  - shots = 0, hits = 0, game_over = 0, win = 0, result = 00
  - FSM -> ARMED
- load_en with ship_map == 0: ignored, no state change.
- ARMED, fire=1 with a valid selection (same-cycle combinational check, not sel_error): latch the cell index and go to RESOLVE. Fire with an invalid selection is dropped and the state is unchanged.
- RESOLVE (exactly one cycle). On exit, result_valid=1 for one cycle. Action by target cell:
  - 01: cell -> 11, hits+1, shots+1, result=10
  - 00: cell -> 10, shots+1, result=01
  - 10 or 11: no change to cell, shots or hits; result=00
- Exit from RESOLVE:
  - hits == ship_total after update -> OVER, win=1
  - else shots == MAX_SHOTS -> OVER, win=0
  - else -> ARMED
- Last shot that both sinks the final ship and exhausts the budget: win has priority (win=1).
- Latency: fire sampled at edge N; cell, counters and result update at edge N+1; result_valid is high for the cycle following edge N+1.
- fire pulses arriving in RESOLVE are ignored, with no queuing.
- load_en in RESOLVE takes priority: the pending shot is discarded, the new game loads and result_valid stays 0.
- OVER: fire ignored. Cells, counters and win hold. Only load_en or reset leaves OVER.
- Counters saturate structurally: shots never exceeds MAX_SHOTS and hits never exceeds ship_total.

Test Plan:
- Reset mid-game (ARMED, shots=3) -> all outputs 0 immediately, FSM IDLE. fire with valid selection -> no change.
- Load ship_map=16'h0001, reveal=0, row_oh=0001, col_oh=0001, fire -> one cycle later cell_state[1:0]=11, hits=1, shots=1, result=10, result_valid pulse, game_over=1, win=1.
- Load 16'h8000. Fire at (0,1) -> result=01, cell_state[3:2]=10, shots=1. Fire (0,1) again -> result=00, shots stays 1.
- row_oh=0011, col_oh=0001, fire -> no state change, sel_error=1 from the next cycle. Fix to row_oh=0001 -> sel_error=0.
- MAX_SHOTS=2, ship_map=16'h8000. Two misses at (0,0) and (0,1) -> game_over=1, win=0, shots=2. A further fire is ignored. load_en -> ARMED with shots=0.
- reveal=1 after loading 16'h8000 -> cell_state[31:30]=01, all other cells 00. Fire in RESOLVE cycle concurrent with load_en -> new game loaded, no result_valid pulse.
